// File: rtl/sim_testutil_multidump.sv
// sim_testutil_multidump
//
// Simulation-only test helper that sits on the bus beside the core and RAM.
// Software programs NumRegions signature regions [BEGIN, END) through the
// device port. It then writes an exit code to HALT. The block walks every
// non-empty region and issues host reads with up to MaxOutstanding reads in
// flight. It prints each returned word and then reports completion.
//
// Register map (byte offsets, only the low DevAddrBits are decoded):
//   0x0          HALT      W   exit code, starts the dump
//   0x4          STATUS    R   {busy, done, 14'b0, words_dumped[15:0]}
//   0x10 + 8*i   BEGIN[i]  RW  region start (bits [1:0] forced to 0)
//   0x14 + 8*i   END[i]    RW  region end, exclusive (bits [1:0] forced to 0)
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   dev_*                  device port; every request gets a response
//                          (rvalid/rdata/err) on the following cycle
//   host_req_o/gnt_i       host read request handshake, addr held until granted
//   host_rvalid_i/rdata_i  in-order read returns
//   done_o                 sticky completion flag
//   exit_code_o            value written to HALT
//
// Configuration:
//   SIM_TESTUTIL_FINISH_EN  when defined, the simulation ends one cycle after
//                           DONE with $finish(exit_code != 0 ? 1 : 0).
//                           When undefined, the block stays in DONE.

module sim_testutil_multidump #(
    parameter int unsigned NumRegions     = 2,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned DevAddrBits    = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dev_req_i,
    input  logic        dev_we_i,
    input  logic [31:0] dev_addr_i,
    input  logic [31:0] dev_wdata_i,
    input  logic [3:0]  dev_be_i,
    output logic        dev_rvalid_o,
    output logic [31:0] dev_rdata_o,
    output logic        dev_err_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    input  logic        host_rvalid_i,
    output logic [31:0] host_addr_o,
    input  logic [31:0] host_rdata_i,
    output logic        done_o,
    output logic [31:0] exit_code_o
);

    localparam int unsigned IdxW = $clog2(NumRegions + 1);
    localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

    typedef enum logic [2:0] {
        StIdle,
        StNext,
        StReq,
        StDrain,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     exit_code_q, exit_code_d;
    logic [OutW-1:0] out_q, out_d;
    logic [15:0]     words_q;
    logic [31:0]     begin_q [NumRegions];
    logic [31:0]     end_q   [NumRegions];

    logic            dev_rvalid_q, dev_err_q;
    logic [31:0]     dev_rdata_q;

    // ---------------------------------------------------------------
    // Device-port decode
    // ---------------------------------------------------------------
    logic [31:0]           dec_addr;
    logic                  is_halt, is_status, rgn_hit;
    logic [NumRegions-1:0] begin_hit, end_hit;
    logic                  busy, done;
    logic                  dev_err_c, dev_wr_ok;
    logic [31:0]           rd_c;

    // Upper address bits are ignored; (1 << 32) wraps to 0 so a full-width
    // decode still yields an all-ones mask.
    assign dec_addr  = dev_addr_i & ((32'd1 << DevAddrBits) - 32'd1);
    assign is_halt   = (dec_addr == 32'h0);
    assign is_status = (dec_addr == 32'h4);

    always_comb begin
        begin_hit = '0;
        end_hit   = '0;
        for (int i = 0; i < NumRegions; i++) begin
            begin_hit[i] = (dec_addr == 32'h10 + 32'(i) * 32'd8);
            end_hit[i]   = (dec_addr == 32'h14 + 32'(i) * 32'd8);
        end
    end

    assign rgn_hit = (|begin_hit) | (|end_hit);
    assign busy    = (state_q == StNext) || (state_q == StReq) || (state_q == StDrain);
    assign done    = (state_q == StDone);

    // Any error suppresses every side effect of the access.
    assign dev_err_c = (dev_be_i != 4'hF)
                     || !(is_halt || is_status || rgn_hit)
                     || (dev_we_i && is_status)
                     || (!dev_we_i && is_halt)
                     || (dev_we_i && busy);
    assign dev_wr_ok = dev_req_i && dev_we_i && !dev_err_c;

    always_comb begin
        rd_c = '0;
        if (is_status) begin
            rd_c = {busy, done, 14'b0, words_q};
        end
        for (int i = 0; i < NumRegions; i++) begin
            if (begin_hit[i]) rd_c = begin_q[i];
            if (end_hit[i])   rd_c = end_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_rvalid_q <= 1'b0;
            dev_err_q    <= 1'b0;
            dev_rdata_q  <= '0;
        end else begin
            dev_rvalid_q <= dev_req_i;
            dev_err_q    <= dev_req_i && dev_err_c;
            dev_rdata_q  <= (dev_req_i && !dev_we_i && !dev_err_c) ? rd_c : 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegions; i++) begin
                begin_q[i] <= '0;
                end_q[i]   <= '0;
            end
        end else if (dev_wr_ok) begin
            for (int i = 0; i < NumRegions; i++) begin
                if (begin_hit[i]) begin_q[i] <= {dev_wdata_i[31:2], 2'b00};
                if (end_hit[i])   end_q[i]   <= {dev_wdata_i[31:2], 2'b00};
            end
        end
    end

    // ---------------------------------------------------------------
    // Dump sequencer
    // ---------------------------------------------------------------
    logic [31:0] cur_begin, cur_end;
    logic        host_hs, rv_acc;

    always_comb begin
        cur_begin = '0;
        cur_end   = '0;
        for (int i = 0; i < NumRegions; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_begin = begin_q[i];
                cur_end   = end_q[i];
            end
        end
    end

    assign host_req_o = (state_q == StReq) && (out_q < OutW'(MaxOutstanding));
    assign host_hs    = host_req_o && host_gnt_i;
    // A return with nothing in flight is treated as noise.
    assign rv_acc     = host_rvalid_i && (out_q != '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        exit_code_d = exit_code_q;
        unique case (state_q)
            StIdle: begin
                if (dev_wr_ok && is_halt) begin
                    state_d     = StNext;
                    idx_d       = '0;
                    exit_code_d = dev_wdata_i;
                end
            end
            StNext: begin
                if (idx_q == IdxW'(NumRegions)) begin
                    state_d = StDrain;
                end else if (cur_end <= cur_begin) begin
                    idx_d = idx_q + IdxW'(1);
                end else begin
                    addr_d  = cur_begin;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (host_hs) begin
                    addr_d = addr_q + 32'd4;
                    if (addr_q + 32'd4 == cur_end) begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StNext;
                    end
                end
            end
            StDrain: begin
                if (out_q == '0) state_d = StDone;
            end
            StDone: begin
                // Sticky until reset; later HALT writes are accepted and ignored.
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d = out_q;
        if (host_hs && !rv_acc)      out_d = out_q + OutW'(1);
        else if (!host_hs && rv_acc) out_d = out_q - OutW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            addr_q      <= '0;
            exit_code_q <= '0;
            out_q       <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            exit_code_q <= exit_code_d;
            out_q       <= out_d;
            if (rv_acc && (words_q != 16'hFFFF)) words_q <= words_q + 16'd1;
        end
    end

    assign dev_rvalid_o = dev_rvalid_q;
    assign dev_rdata_o  = dev_rdata_q;
    assign dev_err_o    = dev_err_q;
    assign host_addr_o  = addr_q;
    assign done_o       = done;
    assign exit_code_o  = exit_code_q;

    // ---------------------------------------------------------------
    // Simulation reporting
    // ---------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (rv_acc) begin
                $display("SIGNATURE: 0x%08x", host_rdata_i);
            end
            if ((state_q == StDrain) && (state_d == StDone)) begin
                $display("sim_testutil_multidump: exit code 0x%08x, %0d words dumped",
                         exit_code_q, words_q);
            end
`ifdef SIM_TESTUTIL_FINISH_EN
            if (state_q == StDone) begin
                if (exit_code_q != 32'h0) $finish(1);
                else                      $finish(0);
            end
`endif
        end
    end
`endif

endmodule
